// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic light controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G,
      NS_Y,
      EW_G,
      EW_Y,
      ALL_RED
   } state_t;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   localparam logic [3:0] BLANK_DIGIT = 4'hA;

   // Constant 0..99 to two packed BCD digits; used only for reload values.
   function automatic logic [7:0] to_bcd(input int unsigned v);
      to_bcd = {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/bcd_down2.sv
// Two-digit BCD down-counter with synchronous load (load beats dec).
module bcd_down2 #(
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic [7:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_VAL;
      end else if (load) begin
         q <= load_val;
      end else if (dec && (q != 8'h00)) begin
         // Ones digit borrows from tens: x0 -> (x-1)9; 00 holds.
         if (q[3:0] == 4'd0) begin
            q <= {q[7:4] - 4'd1, 4'd9};
         end else begin
            q <= {q[7:4], q[3:0] - 4'd1};
         end
      end
   end

endmodule

// File: rtl/traffic_ctrl.sv
// Two-road intersection controller: phase FSM, BCD countdowns, lamps and
// seg-display feed, with an all-red emergency override.
module traffic_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned GREEN_S  = 25,
   parameter int unsigned YELLOW_S = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        emg,
   output logic [2:0]  ns_light,
   output logic [2:0]  ew_light,
   output logic [31:0] dat,
   output logic        pos
);

   localparam int unsigned   PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRES_MAX  = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] PRES_HALF = PW'(CLK_HZ / 2);
   localparam logic [7:0]    G_BCD     = to_bcd(GREEN_S);
   localparam logic [7:0]    Y_BCD     = to_bcd(YELLOW_S);
   localparam logic [7:0]    GY_BCD    = to_bcd(GREEN_S + YELLOW_S);

   if (GREEN_S == 0 || GREEN_S > 94 || YELLOW_S == 0 || YELLOW_S > 9 ||
       GREEN_S + YELLOW_S > 99) begin : g_bad_params
      $error("traffic_ctrl: GREEN_S/YELLOW_S out of range");
   end

   state_t          state_q, state_d;
   logic [PW-1:0]   pres_q, pres_d;
   logic            emg_meta, emg_s;
   logic            tick;
   logic            ns_load, ew_load, ns_dec, ew_dec;
   logic [7:0]      ns_val, ew_val;
   logic [7:0]      ns_cnt, ew_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         emg_meta <= 1'b0;
         emg_s    <= 1'b0;
         state_q  <= NS_G;
         pres_q   <= '0;
      end else begin
         emg_meta <= emg;
         emg_s    <= emg_meta;
         state_q  <= state_d;
         pres_q   <= pres_d;
      end
   end

   assign tick = (pres_q == PRES_MAX);

   always_comb begin
      state_d = state_q;
      pres_d  = pres_q;
      ns_load = 1'b0;
      ew_load = 1'b0;
      ns_dec  = 1'b0;
      ew_dec  = 1'b0;
      ns_val  = G_BCD;
      ew_val  = GY_BCD;
      if (emg_s) begin
         // Preload reset values so leaving ALL_RED starts a fresh NS_G.
         state_d = ALL_RED;
         pres_d  = '0;
         ns_load = 1'b1;
         ew_load = 1'b1;
      end else if (state_q == ALL_RED) begin
         state_d = NS_G;
         pres_d  = '0;
         ns_load = 1'b1;
         ew_load = 1'b1;
      end else begin
         pres_d = tick ? '0 : pres_q + PW'(1);
         if (tick) begin
            ns_dec = 1'b1;
            ew_dec = 1'b1;
            case (state_q)
               NS_G: if (ns_cnt == 8'h01) begin
                  state_d = NS_Y;
                  ns_load = 1'b1;
                  ns_val  = Y_BCD;
               end
               NS_Y: if (ns_cnt == 8'h01) begin
                  state_d = EW_G;
                  ns_load = 1'b1;
                  ew_load = 1'b1;
                  ns_val  = GY_BCD;
                  ew_val  = G_BCD;
               end
               EW_G: if (ew_cnt == 8'h01) begin
                  state_d = EW_Y;
                  ew_load = 1'b1;
                  ew_val  = Y_BCD;
               end
               EW_Y: if (ew_cnt == 8'h01) begin
                  state_d = NS_G;
                  ns_load = 1'b1;
                  ew_load = 1'b1;
                  ns_val  = G_BCD;
                  ew_val  = GY_BCD;
               end
               default: ;
            endcase
         end
      end
   end

   bcd_down2 #(.RST_VAL(G_BCD)) u_ns_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ns_load),
      .load_val (ns_val),
      .dec      (ns_dec),
      .q        (ns_cnt)
   );

   bcd_down2 #(.RST_VAL(GY_BCD)) u_ew_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ew_load),
      .load_val (ew_val),
      .dec      (ew_dec),
      .q        (ew_cnt)
   );

   // Outputs decode flops only, so lamps and dat move together on the edge.
   always_comb begin
      ns_light = LAMP_R;
      ew_light = LAMP_R;
      case (state_q)
         NS_G:    ns_light = LAMP_G;
         NS_Y:    ns_light = LAMP_Y;
         EW_G:    ew_light = LAMP_G;
         EW_Y:    ew_light = LAMP_Y;
         default: ;
      endcase
      if (state_q == ALL_RED) begin
         dat = {4{4'h0, BLANK_DIGIT}};
         pos = 1'b0;
      end else begin
         dat = {4'h0, ns_cnt[7:4], 4'h0, ns_cnt[3:0], 4'h0, ew_cnt[7:4], 4'h0, ew_cnt[3:0]};
         pos = (pres_q < PRES_HALF);
      end
   end

endmodule
